gb_video_timing: RTL

- Raster timing generator and pixel output stage for the Green Beret / Mr. Goemon core.
- Produces the PH/PV pixel counters that drive the core's video and CPU timing.
- Consumes the core's PCLK and 12-bit POUT and emits blanked RGB444 plus HSYNC/VSYNC/HBLK/VBLK to the scan converter.
- All logic runs in the clk48M domain. PCLK (6 MHz, derived from clk48M) is treated as a level; its rising edge forms an internal pixel tick.

---
 rtl/gb_video_pkg.sv | 43 ++++
 rtl/gb_sync_window.sv | 31 +++
 rtl/gb_video_timing.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/gb_video_pkg.sv
// Shared timing constants, colour field layout and offset helpers for the
// Green Beret / Mr. Goemon raster generator.
package gb_video_pkg;

  localparam int CNT_W = 9;
  localparam int CH_W  = 4;
  localparam int PIX_W = 3 * CH_W;

  // POUT / RGB field positions: [3:0]=R, [7:4]=G, [11:8]=B
  localparam int R_LSB = 0;
  localparam int G_LSB = 4;
  localparam int B_LSB = 8;

  localparam int DEF_H_TOTAL     = 384;
  localparam int DEF_H_VIS_START = 8;
  localparam int DEF_H_VIS_END   = 248;
  localparam int DEF_HS_START    = 288;
  localparam int DEF_HS_WIDTH    = 32;
  localparam int DEF_V_TOTAL     = 264;
  localparam int DEF_V_VIS_START = 16;
  localparam int DEF_V_VIS_END   = 240;
  localparam int DEF_VS_START    = 248;
  localparam int DEF_VS_WIDTH    = 8;

  typedef logic signed [3:0]  ofs_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  localparam int SUM_W = CNT_W + 2;

  // base + signed offset, folded back into 0..total-1 (offset magnitude < total)
  function automatic cnt_t wrap_add(input cnt_t base, input ofs_t ofs, input int total);
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] tot;
    tot = SUM_W'(total);
    sum = $signed({2'b00, base}) + $signed({{(SUM_W-4){ofs[3]}}, ofs});
    if (sum < 0)
      sum = sum + tot;
    else if (sum >= tot)
      sum = sum - tot;
    return sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/gb_sync_window.sv
// Counter-range comparator: hit while cnt lies in [start, start+WIDTH),
// with the window allowed to run past TOTAL-1 and continue from 0.
module gb_sync_window
  import gb_video_pkg::*;
#(
  parameter int TOTAL = DEF_H_TOTAL,
  parameter int WIDTH = DEF_HS_WIDTH
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] start,
  output logic             hit
);

  localparam int EW = CNT_W + 1;
  localparam logic [EW-1:0] TOT_E = EW'(TOTAL);

  logic [EW-1:0] stop;
  logic [EW-1:0] cnt_e;

  assign cnt_e = {1'b0, cnt};
  assign stop  = {1'b0, start} + EW'(WIDTH);

  always_comb begin
    hit = 1'b0;
    if (stop <= TOT_E)
      hit = (cnt >= start) && (cnt_e < stop);
    else
      hit = (cnt >= start) || (cnt_e < (stop - TOT_E));
  end

endmodule

// File: rtl/gb_video_timing.sv
// Raster timing generator: PH/PV counters, blank/sync flags and a blanked
// RGB444 output stage, all advancing on the rising edge of PCLK seen in clk48M.
module gb_video_timing
  import gb_video_pkg::*;
#(
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int H_VIS_START = DEF_H_VIS_START,
  parameter int H_VIS_END   = DEF_H_VIS_END,
  parameter int HS_START    = DEF_HS_START,
  parameter int HS_WIDTH    = DEF_HS_WIDTH,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int V_VIS_START = DEF_V_VIS_START,
  parameter int V_VIS_END   = DEF_V_VIS_END,
  parameter int VS_START    = DEF_VS_START,
  parameter int VS_WIDTH    = DEF_VS_WIDTH
) (
  input  logic             clk48M,
  input  logic             reset,
  input  logic             PCLK,
  input  logic [PIX_W-1:0] POUT,
  input  logic [3:0]       HOFS,
  input  logic [3:0]       VOFS,
  output logic [CNT_W-1:0] PH,
  output logic [CNT_W-1:0] PV,
  output logic             HBLK,
  output logic             VBLK,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic [CH_W-1:0]  R,
  output logic [CH_W-1:0]  G,
  output logic [CH_W-1:0]  B,
  output logic             CE_PIX,
  output logic             FRAME
);

  localparam cnt_t H_LAST  = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST  = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_VS    = cnt_t'(H_VIS_START);
  localparam cnt_t H_VE    = cnt_t'(H_VIS_END);
  localparam cnt_t V_VS    = cnt_t'(V_VIS_START);
  localparam cnt_t V_VE    = cnt_t'(V_VIS_END);
  localparam cnt_t HS_BASE = cnt_t'(HS_START);
  localparam cnt_t VS_BASE = cnt_t'(VS_START);

  logic             pclk_q_reg;
  logic             tick;
  cnt_t             ph_reg, pv_reg;
  cnt_t             ph_next, pv_next;
  logic             line_end, frame_end;
  ofs_t             hofs_reg, vofs_reg;
  cnt_t             hs_start, vs_start;
  logic             hs_hit, vs_hit;
  logic             h_vis, v_vis, blank;
  logic             hblk_reg, vblk_reg, hsync_reg, vsync_reg;
  logic             ce_pix_reg, frame_reg;
  logic [PIX_W-1:0] pix_next, pix_reg;

  assign tick = PCLK & ~pclk_q_reg;

  always_comb begin
    line_end  = (ph_reg == H_LAST);
    frame_end = line_end && (pv_reg == V_LAST);
    ph_next   = line_end ? '0 : ph_reg + 1'b1;
    pv_next   = pv_reg;
    if (line_end)
      pv_next = (pv_reg == V_LAST) ? '0 : pv_reg + 1'b1;
  end

  // Offsets only move at frame boundaries so a frame never shows a torn sync.
  assign hs_start = wrap_add(HS_BASE, hofs_reg, H_TOTAL);
  assign vs_start = wrap_add(VS_BASE, vofs_reg, V_TOTAL);

  gb_sync_window #(.TOTAL(H_TOTAL), .WIDTH(HS_WIDTH)) u_hsync_win (
    .cnt   (ph_reg),
    .start (hs_start),
    .hit   (hs_hit)
  );

  gb_sync_window #(.TOTAL(V_TOTAL), .WIDTH(VS_WIDTH)) u_vsync_win (
    .cnt   (pv_reg),
    .start (vs_start),
    .hit   (vs_hit)
  );

  assign h_vis = (ph_reg >= H_VS) && (ph_reg < H_VE);
  assign v_vis = (pv_reg >= V_VS) && (pv_reg < V_VE);
  assign blank = ~(h_vis & v_vis);

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      assign pix_next[gi*CH_W +: CH_W] = blank ? '0 : POUT[gi*CH_W +: CH_W];
    end
  endgenerate

  // Flags and colour are taken from the pre-increment position so they stay
  // paired with each other in the same output cycle.
  always_ff @(posedge clk48M or negedge reset) begin
    if (!reset) begin
      pclk_q_reg <= 1'b0;
      ph_reg     <= '0;
      pv_reg     <= '0;
      hofs_reg   <= '0;
      vofs_reg   <= '0;
      hblk_reg   <= 1'b1;
      vblk_reg   <= 1'b1;
      hsync_reg  <= 1'b0;
      vsync_reg  <= 1'b0;
      pix_reg    <= '0;
      ce_pix_reg <= 1'b0;
      frame_reg  <= 1'b0;
    end else begin
      pclk_q_reg <= PCLK;
      ce_pix_reg <= tick;
      frame_reg  <= tick & frame_end;
      if (tick) begin
        ph_reg    <= ph_next;
        pv_reg    <= pv_next;
        hblk_reg  <= ~h_vis;
        vblk_reg  <= ~v_vis;
        hsync_reg <= hs_hit;
        vsync_reg <= vs_hit;
        pix_reg   <= pix_next;
        if (frame_end) begin
          hofs_reg <= ofs_t'(HOFS);
          vofs_reg <= ofs_t'(VOFS);
        end
      end
    end
  end

  assign PH     = ph_reg;
  assign PV     = pv_reg;
  assign HBLK   = hblk_reg;
  assign VBLK   = vblk_reg;
  assign HSYNC  = hsync_reg;
  assign VSYNC  = vsync_reg;
  assign R      = pix_reg[R_LSB +: CH_W];
  assign G      = pix_reg[G_LSB +: CH_W];
  assign B      = pix_reg[B_LSB +: CH_W];
  assign CE_PIX = ce_pix_reg;
  assign FRAME  = frame_reg;

endmodule
